// File: rtl/wbr_pkg.sv
// Shared types and constants for the word-to-byte reader.
package wbr_pkg;

  localparam int NBYTES = 4;
  localparam int BYTE_W = 8;

  typedef enum logic {
    IDLE = 1'b0,
    SEND = 1'b1
  } state_t;

endpackage

// File: rtl/wbr_byte_sel.sv
// Byte-lane selector: maps a byte counter to a physical lane of the held word
// (LSB-first or MSB-first) and returns that lane's byte.
module wbr_byte_sel
  import wbr_pkg::*;
#(
  parameter int NBYTES = wbr_pkg::NBYTES,
  parameter int BYTE_W = wbr_pkg::BYTE_W
) (
  input  logic [NBYTES*BYTE_W-1:0] word,
  input  logic [1:0]               idx,
  input  logic                     msb_first,
  output logic [1:0]               lane,
  output logic [BYTE_W-1:0]        sel_byte
);

  logic [NBYTES-1:0][BYTE_W-1:0] lanes;

  assign lanes    = word;
  // MSB-first walks down from the top lane, so short words use the top lanes.
  assign lane     = msb_first ? (2'(NBYTES - 1) - idx) : idx;
  assign sel_byte = lanes[lane];

endmodule

// File: rtl/word_byte_reader.sv
// Word-to-byte reader: accepts a 32-bit word with a byte count and streams
// its bytes out one per cycle over a valid/ready interface.
// Build option: WORD_BYTE_READER_MSB_FIRST_EN selects MSB-first byte order.
module word_byte_reader
  import wbr_pkg::*;
#(
  parameter int NBYTES = wbr_pkg::NBYTES,
  parameter int BYTE_W = wbr_pkg::BYTE_W
) (
  input  logic                     clk,
  input  logic                     clear_n,
  input  logic                     flush,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [NBYTES*BYTE_W-1:0] in_data,
  input  logic [1:0]               in_len,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [BYTE_W-1:0]        out_data,
  output logic [1:0]               out_idx,
  output logic                     out_last
);

`ifdef WORD_BYTE_READER_MSB_FIRST_EN
  localparam logic MSB_FIRST = 1'b1;
`else
  localparam logic MSB_FIRST = 1'b0;
`endif

  state_t                    state_q, state_d;
  logic [1:0]                cnt_q, cnt_d;
  logic [NBYTES*BYTE_W-1:0]  word_q;
  logic [1:0]                len_q;
  logic                      sending;
  logic                      load;
  logic [1:0]                sel_lane;
  logic [BYTE_W-1:0]         sel_byte;

  assign sending   = (state_q == SEND);
  assign out_valid = sending;
  assign out_last  = sending && (cnt_q == len_q);
  // Ready in IDLE, or in SEND exactly when the last byte leaves this cycle,
  // which gives back-to-back words with no bubble. Flush and reset block it.
  assign in_ready  = clear_n && !flush && (!sending || (out_ready && out_last));
  assign load      = in_valid && in_ready;

  wbr_byte_sel #(
    .NBYTES (NBYTES),
    .BYTE_W (BYTE_W)
  ) u_sel (
    .word      (word_q),
    .idx       (cnt_q),
    .msb_first (MSB_FIRST),
    .lane      (sel_lane),
    .sel_byte  (sel_byte)
  );

  // Outputs read zero whenever no byte is being offered (including reset).
  assign out_data = sending ? sel_byte : '0;
  assign out_idx  = sending ? sel_lane : '0;

  // Next-state and counter: flush wins, then a new load, then byte consumption.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    if (flush) begin
      state_d = IDLE;
      cnt_d   = '0;
    end else if (load) begin
      state_d = SEND;
      cnt_d   = '0;
    end else if (sending && out_ready) begin
      if (out_last) state_d = IDLE;
      else          cnt_d   = cnt_q + 2'd1;
    end
  end

  // State and byte counter registers.
  always_ff @(posedge clk or negedge clear_n) begin
    if (!clear_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Held word and length, captured on input acceptance.
  always_ff @(posedge clk or negedge clear_n) begin
    if (!clear_n) begin
      word_q <= '0;
      len_q  <= '0;
    end else if (load) begin
      word_q <= in_data;
      len_q  <= in_len;
    end
  end

endmodule

// File: tb/tb_word_byte_reader.sv
// Directed self-checking bench for word_byte_reader.
module tb_word_byte_reader;

  logic        clk = 1'b0;
  logic        clear_n;
  logic        flush;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_data;
  logic [1:0]  in_len;
  logic        out_valid;
  logic        out_ready;
  logic [7:0]  out_data;
  logic [1:0]  out_idx;
  logic        out_last;

  int n_chk  = 0;
  int n_pass = 0;

  word_byte_reader dut (
    .clk       (clk),
    .clear_n   (clear_n),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_len    (in_len),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_idx   (out_idx),
    .out_last  (out_last)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  // Physical lane emitted for the c-th byte of a word.
  function automatic logic [1:0] exp_lane(input int c);
`ifdef WORD_BYTE_READER_MSB_FIRST_EN
    return 2'(3 - c);
`else
    return 2'(c);
`endif
  endfunction

  function automatic logic [7:0] exp_byte(input logic [31:0] w, input int c);
    logic [1:0] l;
    l = exp_lane(c);
    return w[8*l +: 8];
  endfunction

  // Step to the next sampling point (falling edge), let drives settle.
  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic chk_beat(input string tag, input logic [31:0] w, input int c, input logic last);
    chk({tag, "_vld"},  out_valid, 1'b1);
    chk({tag, "_data"}, out_data,  exp_byte(w, c));
    chk({tag, "_idx"},  out_idx,   exp_lane(c));
    chk({tag, "_last"}, out_last,  last);
  endtask

  initial begin
    clear_n = 1'b0; flush = 1'b0; in_valid = 1'b0; in_data = '0;
    in_len = '0; out_ready = 1'b0;

    // Reset state
    #2;
    chk("rst_vld",   out_valid, 1'b0);
    chk("rst_last",  out_last,  1'b0);
    chk("rst_data",  out_data,  8'h00);
    chk("rst_idx",   out_idx,   2'd0);
    chk("rst_ready", in_ready,  1'b0);
    @(negedge clk); clear_n = 1'b1; #1;
    chk("rel_ready", in_ready,  1'b1);
    chk("rel_vld",   out_valid, 1'b0);

    // Single 4-byte word into an always-ready sink
    in_valid = 1'b1; in_data = 32'hA1B2C3D4; in_len = 2'd3; out_ready = 1'b1;
    #1;
    chk("w1_ready", in_ready, 1'b1);
    step(); in_valid = 1'b0; #1;
`ifndef WORD_BYTE_READER_MSB_FIRST_EN
    chk("w1_first_hand", out_data, 8'hD4);
`else
    chk("w1_first_hand", out_data, 8'hA1);
`endif
    for (int c = 0; c < 4; c++) begin
      chk_beat("w1", 32'hA1B2C3D4, c, c == 3);
      chk("w1_inrdy", in_ready, c == 3);
      step();
    end
    chk("w1_done_vld", out_valid, 1'b0);
    chk("w1_done_rdy", in_ready,  1'b1);

    // Two words back-to-back, in_valid held high
    in_valid = 1'b1; in_data = 32'h11223344; in_len = 2'd3;
    step(); in_data = 32'h55667788; #1;
    for (int b = 0; b < 8; b++) begin
      chk_beat("b2b", (b < 4) ? 32'h11223344 : 32'h55667788, b % 4, (b % 4) == 3);
      chk("b2b_inrdy", in_ready, (b % 4) == 3);
      step();
      if (b == 3) begin in_valid = 1'b0; #1; end
    end
    chk("b2b_done_vld", out_valid, 1'b0);

    // Two-byte word with a one-cycle stall
    in_valid = 1'b1; in_data = 32'hDEADBEEF; in_len = 2'd1; out_ready = 1'b1;
    step(); in_valid = 1'b0; #1;
    chk_beat("stall0", 32'hDEADBEEF, 0, 1'b0);
    step(); out_ready = 1'b0; #1;
    chk_beat("stall1", 32'hDEADBEEF, 1, 1'b1);
    chk("stall_inrdy", in_ready, 1'b0);
    step(); out_ready = 1'b1; #1;
    chk_beat("stall2", 32'hDEADBEEF, 1, 1'b1);
    step();
    chk("stall_done_vld", out_valid, 1'b0);
    chk("stall_done_rdy", in_ready,  1'b1);

    // Flush after the second byte
    in_valid = 1'b1; in_data = 32'hA1B2C3D4; in_len = 2'd3;
    step(); in_valid = 1'b0; #1;
    chk_beat("fl0", 32'hA1B2C3D4, 0, 1'b0);
    step();
    chk_beat("fl1", 32'hA1B2C3D4, 1, 1'b0);
    step(); flush = 1'b1; in_valid = 1'b1; in_data = 32'h99999999; #1;
    chk("fl_inrdy", in_ready, 1'b0);
    step(); flush = 1'b0; in_valid = 1'b0; #1;
    chk("fl_vld",   out_valid, 1'b0);
    chk("fl_rdy",   in_ready,  1'b1);
    // Flush in IDLE must block an offered word
    flush = 1'b1; in_valid = 1'b1; #1;
    chk("fl_idle_rdy", in_ready, 1'b0);
    step(); flush = 1'b0; in_valid = 1'b0; #1;
    chk("fl_idle_vld", out_valid, 1'b0);
    in_valid = 1'b1; in_data = 32'h0F1E2D3C; in_len = 2'd2;
    step(); in_valid = 1'b0; #1;
    for (int c = 0; c < 3; c++) begin
      chk_beat("fl_new", 32'h0F1E2D3C, c, c == 2);
      step();
    end
    chk("fl_new_done", out_valid, 1'b0);

    // Asynchronous reset mid-word
    in_valid = 1'b1; in_data = 32'hCAFEF00D; in_len = 2'd3;
    step(); in_valid = 1'b0; #1;
    chk_beat("ar0", 32'hCAFEF00D, 0, 1'b0);
    step(); out_ready = 1'b0; #1;
    chk("ar_pre_vld", out_valid, 1'b1);
    clear_n = 1'b0; #1;
    chk("ar_vld",  out_valid, 1'b0);
    chk("ar_data", out_data,  8'h00);
    chk("ar_rdy",  in_ready,  1'b0);
    step(); clear_n = 1'b1; out_ready = 1'b1; #1;
    chk("ar_rel_rdy", in_ready,  1'b1);
    chk("ar_rel_vld", out_valid, 1'b0);
    step();
    chk("ar_no_stale", out_valid, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
